// File: rtl/cpu_run_sequencer.sv
// Run controller for the 6-bit CPU: loads up to 16 instruction words into cpu RAM,
// then gates PC_ENABLE for a budgeted free run or a single step and captures CPU_OUT.
module cpu_run_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOAD_VALID,
  input  logic [14:0] LOAD_DATA,
  input  logic        LOAD_LAST,
  output logic        LOAD_READY,
  input  logic        RUN,
  input  logic        STEP,
  input  logic        HALT_REQ,
  input  logic [7:0]  CYCLE_LIMIT,
  input  logic [5:0]  CPU_OUT,
  output logic [3:0]  WA,
  output logic [14:0] WD,
  output logic        WE,
  output logic        PC_ENABLE,
  output logic [5:0]  RESULT,
  output logic        RESULT_VALID,
  output logic        BUSY,
  output logic [4:0]  PROG_LEN,
  output logic [7:0]  CYCLES
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StReady = 3'd2;
  localparam logic [2:0] StRun   = 3'd3;
  localparam logic [2:0] StStep  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        load_ready_q, load_ready_d;
  logic [3:0]  wa_q, wa_d;
  logic [14:0] wd_q, wd_d;
  logic        we_q, we_d;
  logic        pc_en_q, pc_en_d;
  logic [5:0]  result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic        busy_q, busy_d;
  logic [4:0]  prog_len_q, prog_len_d;
  logic [7:0]  cycles_q, cycles_d;
  logic [7:0]  limit_q, limit_d;

  logic        hs;
  logic        first_word;
  logic        hit_full;
  logic [7:0]  cyc_inc;

  assign hs      = LOAD_VALID & load_ready_q;
  assign cyc_inc = (cycles_q == 8'hFF) ? 8'hFF : cycles_q + 8'd1;

  always_comb begin
    state_d        = state_q;
    wa_d           = wa_q;
    wd_d           = wd_q;
    we_d           = 1'b0;
    pc_en_d        = pc_en_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    prog_len_d     = prog_len_q;
    cycles_d       = cycles_q;
    limit_d        = limit_q;
    first_word     = 1'b0;
    hit_full       = 1'b0;

    case (state_q)
      StIdle: first_word = hs;
      StLoad: begin
        if (hs) begin
          wa_d       = prog_len_q[3:0];
          wd_d       = LOAD_DATA;
          we_d       = 1'b1;
          prog_len_d = prog_len_q + 5'd1;
          if (LOAD_LAST || prog_len_q == 5'd15) begin
            state_d  = StReady;
            hit_full = (prog_len_q == 5'd15);
          end
        end
      end
      StReady: begin
        // A pending word blocks RUN/STEP even while LOAD_READY is briefly low.
        if (LOAD_VALID) begin
          first_word = load_ready_q;
        end else if (RUN) begin
          cycles_d = 8'd0;
          limit_d  = CYCLE_LIMIT;
          pc_en_d  = 1'b1;
          state_d  = StRun;
        end else if (STEP) begin
          cycles_d = 8'd0;
          pc_en_d  = 1'b1;
          state_d  = StStep;
        end
      end
      StRun: begin
        cycles_d = cyc_inc;
        if (HALT_REQ || (limit_q != 8'd0 && cyc_inc >= limit_q)) begin
          pc_en_d = 1'b0;
          state_d = StDone;
        end
      end
      StStep: begin
        cycles_d = 8'd1;
        pc_en_d  = 1'b0;
        state_d  = StDone;
      end
      StDone: begin
        result_d       = CPU_OUT;
        result_valid_d = 1'b1;
        state_d        = StReady;
      end
      default: begin
        pc_en_d = 1'b0;
        state_d = StIdle;
      end
    endcase

    if (first_word) begin
      wa_d       = 4'd0;
      wd_d       = LOAD_DATA;
      we_d       = 1'b1;
      prog_len_d = 5'd1;
      state_d    = LOAD_LAST ? StReady : StLoad;
    end

    // Hold off the host for the cycle the program fills, so word 17 is not taken as a restart.
    load_ready_d = (state_d == StIdle || state_d == StLoad || state_d == StReady) && !hit_full;
    busy_d       = (state_d != StIdle) && (state_d != StReady);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= StIdle;
      load_ready_q   <= 1'b1;
      wa_q           <= 4'd0;
      wd_q           <= 15'd0;
      we_q           <= 1'b0;
      pc_en_q        <= 1'b0;
      result_q       <= 6'd0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      prog_len_q     <= 5'd0;
      cycles_q       <= 8'd0;
      limit_q        <= 8'd0;
    end else begin
      state_q        <= state_d;
      load_ready_q   <= load_ready_d;
      wa_q           <= wa_d;
      wd_q           <= wd_d;
      we_q           <= we_d;
      pc_en_q        <= pc_en_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      prog_len_q     <= prog_len_d;
      cycles_q       <= cycles_d;
      limit_q        <= limit_d;
    end
  end

  assign LOAD_READY   = load_ready_q;
  assign WA           = wa_q;
  assign WD           = wd_q;
  assign WE           = we_q;
  assign PC_ENABLE    = pc_en_q;
  assign RESULT       = result_q;
  assign RESULT_VALID = result_valid_q;
  assign BUSY         = busy_q;
  assign PROG_LEN     = prog_len_q;
  assign CYCLES       = cycles_q;

endmodule
